// File: rtl/coord_pkg.sv
// Shared constants, state encoding and helpers for the 3D-to-2D coordinate projector.
package coord_pkg;

    localparam int unsigned FX     = 185;
    localparam int unsigned FY     = 185;
    localparam int unsigned CX     = 105;
    localparam int unsigned CY     = 77;
    localparam int unsigned IMG_W  = 4000;
    localparam int unsigned IMG_H  = 2900;
    localparam int unsigned RATE   = IMG_W / 208;
    localparam int unsigned NUM_W  = 25;
    localparam int unsigned DEN_W  = 16;
    localparam int unsigned CRD_W  = 16;
    localparam int unsigned PROD_W = 32;
    localparam int unsigned CNT_W  = $clog2(NUM_W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DIV_X = 3'd2,
        DIV_Y = 3'd3,
        MAP   = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Scale a quotient to image units; the wide product is clamped before narrowing.
    function automatic logic [CRD_W-1:0] scale_clamp(input logic [NUM_W-1:0] q,
                                                     input logic [CRD_W-1:0] lim);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(q) * PROD_W'(RATE);
        if (prod > PROD_W'(lim)) begin
            return lim;
        end
        return CRD_W'(prod);
    endfunction

endpackage

// File: rtl/udiv_serial.sv
// Restoring divider, one quotient bit per cycle; the start cycle performs the first step.
module udiv_serial
    import coord_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic [NUM_W-1:0] quotient,
    output logic             busy,
    output logic             done_c
);

    logic [DEN_W-1:0] rem_q, rem_d;
    logic [NUM_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [DEN_W-1:0] src_rem;
    logic [NUM_W-1:0] src_quo;
    logic [DEN_W:0]   trial;
    logic [DEN_W-1:0] step_rem;
    logic [NUM_W-1:0] step_quo;

    // One restoring step from either the fresh dividend or the running registers.
    always_comb begin
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        src_rem  = start ? '0 : rem_q;
        src_quo  = start ? dividend : quo_q;
        trial    = {src_rem, src_quo[NUM_W-1]};
        if (trial >= {1'b0, divisor}) begin
            step_rem = DEN_W'(trial - {1'b0, divisor});
            step_quo = {src_quo[NUM_W-2:0], 1'b1};
        end else begin
            step_rem = DEN_W'(trial);
            step_quo = {src_quo[NUM_W-2:0], 1'b0};
        end
        if (start) begin
            rem_d  = step_rem;
            quo_d  = step_quo;
            cnt_d  = CNT_W'(NUM_W - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign quotient = quo_q;
    assign busy     = busy_q;
    assign done_c   = busy_q && !start && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/coord_proj_ctrl.sv
// Projects one 3D sample to clamped, quadrant-mirrored 2D image coordinates.
module coord_proj_ctrl
    import coord_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    input  logic [1:0]  quadrant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] x_2d,
    output logic [15:0] y_2d,
    output logic        err,
    output logic        busy
);

    state_e           state_q, state_d;
    logic [15:0]      x_q, x_d, y_q, y_d, z_q, z_d;
    logic [1:0]       quad_q, quad_d;
    logic [NUM_W-1:0] nx_q, nx_d, ny_q, ny_d, qx_q, qx_d;
    logic [CRD_W-1:0] x2d_q, x2d_d, y2d_q, y2d_d;
    logic             err_q, err_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             in_ready_q, in_ready_d;

    logic             div_start_c;
    logic [NUM_W-1:0] div_dividend_c;
    logic [NUM_W-1:0] div_quo;
    logic             div_busy;
    logic             div_done_c;
    logic [CRD_W-1:0] tx_c, ty_c;

    udiv_serial u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start_c),
        .dividend (div_dividend_c),
        .divisor  (z_q),
        .quotient (div_quo),
        .busy     (div_busy),
        .done_c   (div_done_c)
    );

    // Next-state, datapath and output logic.
    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        y_d            = y_q;
        z_d            = z_q;
        quad_d         = quad_q;
        nx_d           = nx_q;
        ny_d           = ny_q;
        qx_d           = qx_q;
        x2d_d          = x2d_q;
        y2d_d          = y2d_q;
        err_d          = err_q;
        out_valid_d    = out_valid_q;
        div_start_c    = 1'b0;
        div_dividend_c = nx_q;
        tx_c           = '0;
        ty_c           = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = x;
                    y_d     = y;
                    z_d     = z;
                    quad_d  = quadrant;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                nx_d = NUM_W'(FX) * NUM_W'(x_q) + NUM_W'(CX) * NUM_W'(z_q);
                ny_d = NUM_W'(FY) * NUM_W'(y_q) + NUM_W'(CY) * NUM_W'(z_q);
                if (z_q == 16'd0) begin
                    err_d   = 1'b1;
                    state_d = MAP;
                end else begin
                    state_d = DIV_X;
                end
            end
            DIV_X: begin
                div_dividend_c = nx_q;
                if (!div_busy) begin
                    div_start_c = 1'b1;
                end else if (div_done_c) begin
                    state_d = DIV_Y;
                end
            end
            DIV_Y: begin
                div_dividend_c = ny_q;
                if (!div_busy) begin
                    div_start_c = 1'b1;
                    qx_d        = div_quo;
                end else if (div_done_c) begin
                    state_d = MAP;
                end
            end
            MAP: begin
                if (!err_q) begin
                    tx_c = scale_clamp(qx_q, CRD_W'(IMG_W));
                    ty_c = scale_clamp(div_quo, CRD_W'(IMG_H));
                end
                x2d_d       = (quad_q == 2'd0 || quad_q == 2'd3) ? tx_c : CRD_W'(IMG_W) - tx_c;
                y2d_d       = quad_q[1] ? ty_c : CRD_W'(IMG_H) - ty_c;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    err_d       = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d     = (state_d != IDLE);
        in_ready_d = (state_d == IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            quad_q      <= '0;
            nx_q        <= '0;
            ny_q        <= '0;
            qx_q        <= '0;
            x2d_q       <= '0;
            y2d_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            quad_q      <= quad_d;
            nx_q        <= nx_d;
            ny_q        <= ny_d;
            qx_q        <= qx_d;
            x2d_q       <= x2d_d;
            y2d_q       <= y2d_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign x_2d      = x2d_q;
    assign y_2d      = y2d_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_coord_proj_ctrl.sv
// Self-checking bench for coord_proj_ctrl: directed vectors, random samples, reset abort.
module tb_coord_proj_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x, y, z;
    logic [1:0]  quadrant;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] x_2d, y_2d;
    logic        err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    coord_proj_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .z         (z),
        .quadrant  (quadrant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_2d      (x_2d),
        .y_2d      (y_2d),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: pinhole projection, floor division, scale by 19, clamp, mirror by quadrant.
    function automatic void model(input longint mx, input longint my, input longint mz,
                                  input int mq, output logic [15:0] ex,
                                  output logic [15:0] ey, output logic ee);
        longint tx, ty, qx, qy;
        if (mz == 0) begin
            tx = 0;
            ty = 0;
            ee = 1'b1;
        end else begin
            qx = (185 * mx + 105 * mz) / mz;
            qy = (185 * my + 77 * mz) / mz;
            tx = (qx * 19 > 4000) ? 4000 : qx * 19;
            ty = (qy * 19 > 2900) ? 2900 : qy * 19;
            ee = 1'b0;
        end
        ex = (mq == 0 || mq == 3) ? 16'(tx) : 16'(4000 - tx);
        ey = (mq >= 2) ? 16'(ty) : 16'(2900 - ty);
    endfunction

    task automatic run_txn(input logic [15:0] tx, input logic [15:0] ty, input logic [15:0] tz,
                           input logic [1:0] tq, input int hold, input bit noise);
        logic [15:0] ex, ey;
        logic        ee;
        int          n;
        int          exp_lat;
        model(longint'(tx), longint'(ty), longint'(tz), int'(tq), ex, ey, ee);
        exp_lat = (tz == 16'd0) ? 3 : 53;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        x = tx;
        y = ty;
        z = tz;
        quadrant = tq;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n = 1;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("in_ready_after_accept", 32'(in_ready), 32'd0);
        while (out_valid !== 1'b1 && n < 200) begin
            if (noise) begin
                in_valid  = 1'($urandom_range(1, 0));
                x         = 16'($urandom);
                y         = 16'($urandom);
                z         = 16'($urandom);
                quadrant  = 2'($urandom);
                out_ready = 1'($urandom_range(1, 0));
            end
            @(negedge clk);
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("latency", 32'(n), 32'(exp_lat));
        chk("x_2d", 32'(x_2d), 32'(ex));
        chk("y_2d", 32'(y_2d), 32'(ey));
        chk("err", 32'(err), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_x", 32'(x_2d), 32'(ex));
            chk("hold_y", 32'(y_2d), 32'(ey));
            chk("hold_err", 32'(err), 32'(ee));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_after_hs", 32'(out_valid), 32'd0);
        chk("err_after_hs", 32'(err), 32'd0);
        chk("in_ready_after_hs", 32'(in_ready), 32'd1);
        chk("busy_after_hs", 32'(busy), 32'd0);
    endtask

    initial begin
        bit seen_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;
        z         = '0;
        quadrant  = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_x_2d", 32'(x_2d), 32'd0);
        chk("rst_y_2d", 32'(y_2d), 32'd0);
        rst_n = 1'b1;

        // Directed vectors.
        run_txn(16'd40, 16'd20, 16'd160, 2'd0, 10, 1'b0);
        run_txn(16'd40, 16'd20, 16'd160, 2'd1, 0, 1'b0);
        run_txn(16'd40, 16'd20, 16'd160, 2'd3, 1, 1'b0);
        run_txn(16'd0, 16'd0, 16'd160, 2'd2, 0, 1'b0);
        run_txn(16'd65535, 16'd0, 16'd1, 2'd0, 0, 1'b0);
        run_txn(16'd65535, 16'd65535, 16'd65535, 2'd2, 0, 1'b0);
        run_txn(16'd1234, 16'd4321, 16'd0, 2'd0, 2, 1'b0);
        run_txn(16'd7, 16'd9, 16'd0, 2'd3, 0, 1'b1);

        // Reset in the middle of the Y division.
        @(negedge clk);
        in_valid = 1'b1;
        x = 16'd500;
        y = 16'd600;
        z = 16'd70;
        quadrant = 2'd1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        seen_valid = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        chk("abort_no_result", 32'(seen_valid), 32'd0);
        run_txn(16'd40, 16'd20, 16'd160, 2'd0, 0, 1'b0);

        // Random samples with noisy in_valid/out_ready while the block is working.
        for (int k = 0; k < 10; k++) begin
            logic [15:0] rz;
            rz = ($urandom_range(4, 0) == 0) ? 16'd0 : 16'($urandom_range(65535, 1));
            if (k == 3) rz = 16'($urandom_range(8, 1));
            run_txn(16'($urandom), 16'($urandom), rz, 2'($urandom),
                    int'($urandom_range(3, 0)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
